// File: rtl/exe_pkg.sv
// Shared definitions for the matrix-engine sequencer: opcodes, FSM states,
// instruction field layout and default widths.
package exe_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 64;

    // Instruction word field positions
    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 11;
    localparam int DST_MSB  = 10;
    localparam int DST_LSB  = 8;
    localparam int SRCA_MSB = 7;
    localparam int SRCA_LSB = 5;
    localparam int SRCB_MSB = 4;
    localparam int SRCB_LSB = 2;

    // Opcodes; anything not listed here is illegal
    localparam logic [4:0] OP_NOP       = 5'h00;
    localparam logic [4:0] OP_ADD       = 5'h01;
    localparam logic [4:0] OP_SUB       = 5'h02;
    localparam logic [4:0] OP_SCALE     = 5'h03;
    localparam logic [4:0] OP_MULT      = 5'h04;
    localparam logic [4:0] OP_TRANSPOSE = 5'h05;
    localparam logic [4:0] OP_STORE     = 5'h06;
    localparam logic [4:0] OP_HALT      = 5'h1F;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_WAIT   = 3'd4,
        S_WB     = 3'd5,
        S_HALTED = 3'd6
    } state_e;

    typedef struct packed {
        logic [4:0] opcode;
        logic [2:0] dst;
        logic [2:0] src_a;
        logic [2:0] src_b;
        logic [1:0] rsvd;
    } instr_t;

    // Split a raw ROM word into its fields
    function automatic instr_t unpack_instr(input logic [15:0] w);
        instr_t r;
        r.opcode = w[OPC_MSB:OPC_LSB];
        r.dst    = w[DST_MSB:DST_LSB];
        r.src_a  = w[SRCA_MSB:SRCA_LSB];
        r.src_b  = w[SRCB_MSB:SRCB_LSB];
        r.rsvd   = w[1:0];
        return r;
    endfunction

endpackage

// File: rtl/exe_sequencer_if.sv
// Handshake bundle between the sequencer (master) and its ROM / execution
// unit environment (slave).
interface exe_sequencer_if #(parameter int ADDR_W = exe_pkg::ADDR_W_DEF);

    logic              start;
    logic [ADDR_W-1:0] instr_addr;
    logic [15:0]       instr_data;
    logic [2:0]        src_a;
    logic [2:0]        src_b;
    logic [2:0]        dst;
    logic              read_from;
    logic              add_en;
    logic              scale_en;
    logic              mult_en;
    logic              transpose_en;
    logic              add_or_sub;
    logic              unit_done;
    logic              write_to_reg;
    logic              write_to_mem;
    logic              busy;
    logic              halted;
    logic              err_illegal;
    logic              err_timeout;

    modport master (
        input  start, instr_data, unit_done,
        output instr_addr, src_a, src_b, dst, read_from,
               add_en, scale_en, mult_en, transpose_en, add_or_sub,
               write_to_reg, write_to_mem, busy, halted,
               err_illegal, err_timeout
    );

    modport slave (
        output start, instr_data, unit_done,
        input  instr_addr, src_a, src_b, dst, read_from,
               add_en, scale_en, mult_en, transpose_en, add_or_sub,
               write_to_reg, write_to_mem, busy, halted,
               err_illegal, err_timeout
    );

endinterface

// File: rtl/exe_sequencer_wait_timer.sv
// Cycle counter for handshake waits. o_expired flags the TIMEOUT-th
// counted cycle, so the owner can act on it in that same cycle.
module wait_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    // r_cnt holds the number of earlier counted cycles, so the current
    // cycle is the TIMEOUT-th one when r_cnt == TIMEOUT-1.
    assign o_expired = i_en && (r_cnt == CW'(TIMEOUT - 1));

    // Count enabled cycles, saturating at the expiry point
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/exe_sequencer.sv
// Handshake-driven instruction sequencer: fetch from a synchronous ROM,
// decode, issue to one execution unit, wait for its done pulse, commit.
module exe_sequencer
    import exe_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    exe_sequencer_if.master bus
);

    state_e            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [2:0]        r_src_a;
    logic [2:0]        r_src_b;
    logic [2:0]        r_dst;
    logic              r_read_from;
    logic              r_add_en;
    logic              r_scale_en;
    logic              r_mult_en;
    logic              r_transpose_en;
    logic              r_add_or_sub;
    logic              r_write_to_reg;
    logic              r_write_to_mem;
    logic              r_busy;
    logic              r_halted;
    logic              r_err_illegal;
    logic              r_err_timeout;

    instr_t            w_instr;
    logic              w_tmr_clr;
    logic              w_tmr_en;
    logic              w_expired;
    logic              w_unused;

    assign w_instr  = unpack_instr(bus.instr_data);
    assign w_unused = ^w_instr.rsvd;

    // Timer restarts while the operation is being issued and counts WAIT cycles
    assign w_tmr_clr = (r_state == S_ISSUE);
    assign w_tmr_en  = (r_state == S_WAIT);

    wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk       (clk),
        .rst_n     (reset),
        .i_clr     (w_tmr_clr),
        .i_en      (w_tmr_en),
        .o_expired (w_expired)
    );

    // Sequencer FSM; every output is a register updated on the transition
    // into the state where it must be visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_pc           <= '0;
            r_src_a        <= '0;
            r_src_b        <= '0;
            r_dst          <= '0;
            r_read_from    <= 1'b0;
            r_add_en       <= 1'b0;
            r_scale_en     <= 1'b0;
            r_mult_en      <= 1'b0;
            r_transpose_en <= 1'b0;
            r_add_or_sub   <= 1'b0;
            r_write_to_reg <= 1'b0;
            r_write_to_mem <= 1'b0;
            r_busy         <= 1'b0;
            r_halted       <= 1'b0;
            r_err_illegal  <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            // Single-cycle pulses drop unless re-armed below
            r_read_from    <= 1'b0;
            r_add_en       <= 1'b0;
            r_scale_en     <= 1'b0;
            r_mult_en      <= 1'b0;
            r_transpose_en <= 1'b0;
            r_write_to_reg <= 1'b0;
            r_write_to_mem <= 1'b0;

            case (r_state)
                S_IDLE, S_HALTED: begin
                    if (bus.start) begin
                        r_state       <= S_FETCH;
                        r_pc          <= '0;
                        r_busy        <= 1'b1;
                        r_halted      <= 1'b0;
                        r_err_illegal <= 1'b0;
                        r_err_timeout <= 1'b0;
                    end
                end

                // instr_addr already equals PC; ROM data shows up in DECODE
                S_FETCH: r_state <= S_DECODE;

                S_DECODE: begin
                    r_dst   <= w_instr.dst;
                    r_src_a <= w_instr.src_a;
                    r_src_b <= w_instr.src_b;
                    case (w_instr.opcode)
                        OP_NOP: begin
                            r_pc    <= r_pc + 1'b1;
                            r_state <= S_FETCH;
                        end
                        OP_ADD, OP_SUB, OP_SCALE, OP_MULT, OP_TRANSPOSE: begin
                            r_state        <= S_ISSUE;
                            r_read_from    <= 1'b1;
                            r_add_or_sub   <= (w_instr.opcode == OP_SUB);
                            r_add_en       <= (w_instr.opcode == OP_ADD) ||
                                              (w_instr.opcode == OP_SUB);
                            r_scale_en     <= (w_instr.opcode == OP_SCALE);
                            r_mult_en      <= (w_instr.opcode == OP_MULT);
                            r_transpose_en <= (w_instr.opcode == OP_TRANSPOSE);
                        end
                        OP_STORE: begin
                            // No unit involved: commit straight away
                            r_state        <= S_WB;
                            r_write_to_mem <= 1'b1;
                        end
                        OP_HALT: begin
                            r_state  <= S_HALTED;
                            r_busy   <= 1'b0;
                            r_halted <= 1'b1;
                        end
                        default: begin
                            // Unknown opcode: flag it and step over like a NOP
                            r_err_illegal <= 1'b1;
                            r_pc          <= r_pc + 1'b1;
                            r_state       <= S_FETCH;
                        end
                    endcase
                end

                S_ISSUE: r_state <= S_WAIT;

                S_WAIT: begin
                    // A done arriving on the expiry cycle still completes
                    if (bus.unit_done) begin
                        r_state        <= S_WB;
                        r_write_to_reg <= 1'b1;
                    end else if (w_expired) begin
                        r_state       <= S_HALTED;
                        r_err_timeout <= 1'b1;
                        r_busy        <= 1'b0;
                        r_halted      <= 1'b1;
                        r_add_or_sub  <= 1'b0;
                    end
                end

                S_WB: begin
                    r_pc         <= r_pc + 1'b1;
                    r_state      <= S_FETCH;
                    r_add_or_sub <= 1'b0;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.instr_addr   = r_pc;
    assign bus.src_a        = r_src_a;
    assign bus.src_b        = r_src_b;
    assign bus.dst          = r_dst;
    assign bus.read_from    = r_read_from;
    assign bus.add_en       = r_add_en;
    assign bus.scale_en     = r_scale_en;
    assign bus.mult_en      = r_mult_en;
    assign bus.transpose_en = r_transpose_en;
    assign bus.add_or_sub   = r_add_or_sub;
    assign bus.write_to_reg = r_write_to_reg;
    assign bus.write_to_mem = r_write_to_mem;
    assign bus.busy         = r_busy;
    assign bus.halted       = r_halted;
    assign bus.err_illegal  = r_err_illegal;
    assign bus.err_timeout  = r_err_timeout;

endmodule

// File: tb/tb_exe_sequencer.sv
// Bench for exe_sequencer: programs run against a cycle-count model that
// predicts every enable/commit pulse, the halt cycle, final PC and errors.
module tb_exe_sequencer;

    localparam int AW  = 8;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exe_sequencer_if #(.ADDR_W(AW)) bus();

    exe_sequencer #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    // Synchronous instruction ROM
    logic [15:0] rom [256];
    always @(posedge clk) bus.instr_data <= rom[bus.instr_addr];

    // kind: 0 add_en 1 scale_en 2 mult_en 3 transpose_en 4 write_to_reg 5 write_to_mem
    typedef struct {
        int         cyc;
        int         kind;
        logic [2:0] d;
        logic [2:0] a;
        logic [2:0] b;
        logic       sub;
        logic       rf;
    } ev_t;

    int   total = 0;
    int   bad = 0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];
    int   lat[$];       // done latency per issued op, 0 = never
    int   exp_halt;
    int   exp_pc;
    logic exp_ill;
    logic exp_to;

    function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] d,
                                       input logic [2:0] a, input logic [2:0] b);
        return {op, d, a, b, 2'b00};
    endfunction

    function automatic int lat_of(input int i);
        return (i < lat.size()) ? lat[i] : 1;
    endfunction

    function automatic logic [AW+20:0] outs();
        return {bus.instr_addr, bus.src_a, bus.src_b, bus.dst, bus.read_from,
                bus.add_en, bus.scale_en, bus.mult_en, bus.transpose_en,
                bus.add_or_sub, bus.write_to_reg, bus.write_to_mem,
                bus.busy, bus.halted, bus.err_illegal, bus.err_timeout};
    endfunction

    // Walk the program with the per-instruction cycle costs: fetch of an
    // instruction at cycle t, decode t+1, unit enable t+2, done after L
    // wait cycles, commit t+3+L; NOP 2 cycles, STORE 3, timeout after TMO.
    task automatic build_model();
        int t, pc, ei, l;
        logic [15:0] w;
        logic [4:0] op;
        ev_t e;
        exp_q.delete();
        t = 1; pc = 0; ei = 0;
        exp_ill = 1'b0; exp_to = 1'b0; exp_halt = 0;
        for (int g = 0; g < 4096; g++) begin
            w = rom[pc];
            op = w[15:11];
            e.d = w[10:8]; e.a = w[7:5]; e.b = w[4:2];
            e.sub = (op == 5'h02);
            if (op == 5'h1F) begin
                exp_halt = t + 2;
                break;
            end
            if (op >= 5'd1 && op <= 5'd5) begin
                e.cyc = t + 2; e.kind = (op <= 5'd2) ? 0 : int'(op) - 2; e.rf = 1'b1;
                exp_q.push_back(e);
                l = lat_of(ei); ei++;
                if (l == 0) begin
                    exp_to = 1'b1;
                    exp_halt = t + 3 + TMO;
                    break;
                end
                e.cyc = t + 3 + l; e.kind = 4; e.rf = 1'b0;
                exp_q.push_back(e);
                t += 4 + l;
            end else if (op == 5'd6) begin
                e.cyc = t + 2; e.kind = 5; e.rf = 1'b0;
                exp_q.push_back(e);
                t += 3;
            end else begin
                if (op != 5'd0) exp_ill = 1'b1;
                t += 2;
            end
            pc = (pc + 1) % 256;
        end
        exp_pc = pc;
    endtask

    task automatic collect(input int k, output bit en);
        logic [5:0] s;
        ev_t e;
        s = {bus.write_to_mem, bus.write_to_reg, bus.transpose_en,
             bus.mult_en, bus.scale_en, bus.add_en};
        en = |s[3:0];
        for (int i = 0; i < 6; i++) begin
            if (s[i] === 1'b1) begin
                e.cyc = k; e.kind = i; e.d = bus.dst; e.a = bus.src_a; e.b = bus.src_b;
                e.sub = bus.add_or_sub; e.rf = bus.read_from;
                obs_q.push_back(e);
            end
        end
    endtask

    // Start the program in rom[], answer enables with done after lat[],
    // optionally with ignored noise on start/unit_done, then compare.
    task automatic run_prog(input string name, input bit noise);
        int done_at, ei, obs_halt, busy_bad;
        bit en_now;
        build_model();
        obs_q.delete();
        done_at = -1; ei = 0; obs_halt = -1; busy_bad = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.unit_done = 1'b0;
        for (int k = 1; k <= exp_halt + 2; k++) begin
            @(negedge clk);
            if (k == 1) begin
                total++;
                if (bus.instr_addr !== 8'd0 || bus.busy !== 1'b1 || bus.halted !== 1'b0 ||
                    bus.err_illegal !== 1'b0 || bus.err_timeout !== 1'b0) begin
                    bad++;
                    $display("FAIL %s restart: addr=%0d busy=%b halted=%b ill=%b to=%b, required 0 1 0 0 0",
                             name, bus.instr_addr, bus.busy, bus.halted, bus.err_illegal, bus.err_timeout);
                end
            end
            if (bus.halted === 1'b1 && obs_halt < 0) obs_halt = k;
            if (bus.busy !== ((k < exp_halt) ? 1'b1 : 1'b0)) busy_bad++;
            collect(k, en_now);
            if (en_now) begin
                done_at = (lat_of(ei) == 0) ? -1 : k + lat_of(ei);
                ei++;
            end
            bus.unit_done = (k == done_at) || (noise && en_now && ($urandom_range(1) == 1));
            bus.start = noise && (k < exp_halt - 1) && ($urandom_range(3) == 0);
        end
        bus.start = 1'b0;
        bus.unit_done = 1'b0;

        total++;
        if (obs_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL %s pulse count: got %0d, required %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].kind !== exp_q[i].kind ||
                obs_q[i].d !== exp_q[i].d || obs_q[i].a !== exp_q[i].a ||
                obs_q[i].b !== exp_q[i].b || obs_q[i].sub !== exp_q[i].sub ||
                obs_q[i].rf !== exp_q[i].rf) begin
                bad++;
                $display("FAIL %s pulse%0d: got cyc=%0d kind=%0d d=%0d a=%0d b=%0d sub=%b rf=%b, required cyc=%0d kind=%0d d=%0d a=%0d b=%0d sub=%b rf=%b",
                         name, i, obs_q[i].cyc, obs_q[i].kind, obs_q[i].d, obs_q[i].a, obs_q[i].b,
                         obs_q[i].sub, obs_q[i].rf, exp_q[i].cyc, exp_q[i].kind, exp_q[i].d,
                         exp_q[i].a, exp_q[i].b, exp_q[i].sub, exp_q[i].rf);
            end
        end
        total++;
        if (obs_halt !== exp_halt) begin
            bad++;
            $display("FAIL %s halt cycle: got %0d, required %0d", name, obs_halt, exp_halt);
        end
        total++;
        if (bus.instr_addr !== AW'(exp_pc)) begin
            bad++;
            $display("FAIL %s final pc: got %0d, required %0d", name, bus.instr_addr, exp_pc);
        end
        total++;
        if (bus.err_illegal !== exp_ill || bus.err_timeout !== exp_to) begin
            bad++;
            $display("FAIL %s errors: got ill=%b to=%b, required ill=%b to=%b",
                     name, bus.err_illegal, bus.err_timeout, exp_ill, exp_to);
        end
        total++;
        if (busy_bad !== 0) begin
            bad++;
            $display("FAIL %s busy: %0d cycles wrong, required 0", name, busy_bad);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        lat.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if (outs() !== '0) begin
            bad++;
            $display("FAIL reset outputs: got %h, required 0", outs());
        end
        rst_n = 1'b1;
        @(negedge clk);
        bus.unit_done = 1'b1;
        @(negedge clk);
        bus.unit_done = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (outs() !== '0) begin
            bad++;
            $display("FAIL idle ignores done: got %h, required 0", outs());
        end
    endtask

    task automatic test_add_halt();
        clear_rom();
        rom[0] = mk(5'h01, 3'd1, 3'd2, 3'd3);
        rom[1] = mk(5'h1F, 3'd0, 3'd0, 3'd0);
        lat.push_back(2);
        run_prog("add_halt", 1'b0);
    endtask

    task automatic test_sub_mult();
        clear_rom();
        rom[0] = mk(5'h02, 3'd4, 3'd5, 3'd6);
        rom[1] = mk(5'h04, 3'd7, 3'd1, 3'd2);
        rom[2] = mk(5'h1F, 3'd0, 3'd0, 3'd0);
        lat.push_back(1);
        lat.push_back(1);
        run_prog("sub_mult", 1'b0);
    endtask

    task automatic test_illegal();
        clear_rom();
        rom[0] = mk(5'h0A, 3'd3, 3'd3, 3'd3);
        rom[1] = mk(5'h1F, 3'd0, 3'd0, 3'd0);
        run_prog("illegal", 1'b0);
        run_prog("illegal_again", 1'b0);
    endtask

    task automatic test_store();
        clear_rom();
        rom[0] = mk(5'h06, 3'd2, 3'd5, 3'd1);
        rom[1] = mk(5'h03, 3'd6, 3'd0, 3'd7);
        rom[2] = mk(5'h1F, 3'd0, 3'd0, 3'd0);
        lat.push_back(3);
        run_prog("store_scale", 1'b0);
    endtask

    task automatic test_timeout();
        clear_rom();
        rom[0] = mk(5'h05, 3'd3, 3'd4, 3'd5);
        rom[1] = mk(5'h1F, 3'd0, 3'd0, 3'd0);
        lat.push_back(0);
        run_prog("timeout", 1'b0);
        lat.delete();
        lat.push_back(TMO);
        run_prog("done_on_last", 1'b0);
    endtask

    task automatic test_random();
        int n;
        logic [4:0] op;
        logic [10:0] f;
        int r;
        for (int p = 0; p < 25; p++) begin
            clear_rom();
            n = $urandom_range(3, 12);
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(9);
                if (r == 5)      op = 5'h06;
                else if (r == 6) op = 5'h00;
                else if (r == 7) op = 5'($urandom_range(7, 30));
                else             op = 5'($urandom_range(1, 5));
                f = 11'($urandom());
                rom[i] = {op, f};
                if (op >= 5'd1 && op <= 5'd5)
                    lat.push_back(($urandom_range(9) == 0) ? 0 : $urandom_range(1, TMO));
            end
            f = 11'($urandom());
            rom[n] = {5'h1F, f};
            run_prog("random", 1'b1);
        end
    endtask

    task automatic test_wrap();
        int busy_bad;
        logic [AW-1:0] a_hi, a_lo;
        clear_rom();
        busy_bad = 0;
        a_hi = '0; a_lo = '1;
        @(negedge clk);
        bus.start = 1'b1;
        for (int k = 1; k <= 520; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.busy !== 1'b1) busy_bad++;
            if (k == 511) a_hi = bus.instr_addr;
            if (k == 513) a_lo = bus.instr_addr;
        end
        total++;
        if (a_hi !== 8'd255 || a_lo !== 8'd0) begin
            bad++;
            $display("FAIL wrap addr: got %0d then %0d, required 255 then 0", a_hi, a_lo);
        end
        total++;
        if (busy_bad !== 0 || bus.err_illegal !== 1'b0) begin
            bad++;
            $display("FAIL wrap busy: %0d idle cycles ill=%b, required 0 and 0", busy_bad, bus.err_illegal);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mid_reset();
        int strobes, busy_hits;
        clear_rom();
        rom[0] = mk(5'h04, 3'd5, 3'd6, 3'd7);
        rom[1] = mk(5'h1F, 3'd0, 3'd0, 3'd0);
        strobes = 0; busy_hits = 0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (outs() !== '0) begin
            bad++;
            $display("FAIL reset in wait: got %h, required 0", outs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.unit_done = 1'b1;
        @(negedge clk);
        bus.unit_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if ((bus.write_to_reg | bus.write_to_mem | bus.add_en | bus.scale_en |
                 bus.mult_en | bus.transpose_en) !== 1'b0) strobes++;
            if (bus.busy !== 1'b0 || bus.halted !== 1'b0) busy_hits++;
            @(negedge clk);
        end
        total++;
        if (strobes !== 0 || busy_hits !== 0) begin
            bad++;
            $display("FAIL late done: got %0d strobes %0d busy cycles, required 0 0", strobes, busy_hits);
        end
        rom[0] = mk(5'h01, 3'd2, 3'd3, 3'd4);
        lat.push_back(1);
        run_prog("after_reset", 1'b0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.unit_done = 1'b0;
        bus.instr_data = 16'h0000;
        clear_rom();
        test_reset();
        test_add_halt();
        test_sub_mult();
        test_illegal();
        test_store();
        test_timeout();
        test_random();
        test_wrap();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
